// File: rtl/dm_sized_if.sv
// Request/response bundle for the sized data memory: the master issues accesses,
// the memory (slave) reports busy/ack and the load result.
interface dm_sized_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic        ack;
    logic [31:0] data_out;
    logic        misalign;

    modport master (
        output req, we, size, sign_ext, addr, data_in,
        input  busy, ack, data_out, misalign
    );

    modport slave (
        input  req, we, size, sign_ext, addr, data_in,
        output busy, ack, data_out, misalign
    );
endinterface

// File: rtl/dm_sized.sv
// Byte-addressed little-endian data memory with byte/halfword/word accesses,
// sign/zero-extended loads, a fixed-latency req/ack handshake and a misalign flag.
module dm_sized #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    dm_sized_if.slave bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [2:0] WAIT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;

    logic [7:0]        mem [DEPTH];

    logic              we_reg;
    logic              sx_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       din_reg;
    logic [31:0]       dout_reg;
    logic              mis_reg;

    logic              accept;
    logic              do_access;
    logic              we_cur;
    logic              sx_cur;
    logic [1:0]        size_cur;
    logic [ADDR_W-1:0] addr_cur;
    logic [31:0]       din_cur;
    logic              mis_cur;
    logic [3:0]        byte_en;
    logic [7:0]        rd_byte [4];
    logic [31:0]       rd_word;
    logic [31:0]       ld_value;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    assign accept = bus.req && (state_reg == S_IDLE || state_reg == S_ACK);

    // With a single-cycle latency the access happens on the accepting edge,
    // before the request registers have captured the fields.
    assign we_cur   = accept ? bus.we                  : we_reg;
    assign sx_cur   = accept ? bus.sign_ext            : sx_reg;
    assign size_cur = accept ? bus.size                : size_reg;
    assign addr_cur = accept ? bus.addr[ADDR_W-1:0]    : addr_reg;
    assign din_cur  = accept ? bus.data_in             : din_reg;

    always_comb begin
        mis_cur = 1'b0;
        byte_en = 4'b1111;
        case (size_cur)
            2'b00: begin mis_cur = 1'b0;           byte_en = 4'b0001; end
            2'b01: begin mis_cur = addr_cur[0];    byte_en = 4'b0011; end
            default: begin mis_cur = |addr_cur[1:0]; byte_en = 4'b1111; end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_byte[gi] = mem[addr_cur + ADDR_W'(gi)];
        end
    endgenerate

    assign rd_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    always_comb begin
        ld_value = rd_word;
        case (size_cur)
            2'b00: ld_value = {{24{sx_cur & rd_word[7]}},  rd_word[7:0]};
            2'b01: ld_value = {{16{sx_cur & rd_word[15]}}, rd_word[15:0]};
            default: ld_value = rd_word;
        endcase
    end

    // cnt_reg holds the number of WAIT cycles still to go, including the current one.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_access  = 1'b0;
        case (state_reg)
            S_IDLE, S_ACK: begin
                if (bus.req) begin
                    if (LATENCY == 1) begin
                        state_next = S_ACK;
                        do_access  = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    state_next = S_ACK;
                    do_access  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            sx_reg    <= 1'b0;
            size_reg  <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
            dout_reg  <= '0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg   <= bus.we;
                sx_reg   <= bus.sign_ext;
                size_reg <= bus.size;
                addr_reg <= bus.addr[ADDR_W-1:0];
                din_reg  <= bus.data_in;
            end
            if (do_access) begin
                mis_reg <= mis_cur;
                if (!we_cur && !mis_cur) begin
                    dout_reg <= ld_value;
                end
            end
        end
    end

    // Aligned accesses never straddle the top of memory, so addr_cur+k never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (do_access && we_cur && !mis_cur) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[addr_cur + ADDR_W'(k)] <= din_cur[8*k +: 8];
                end
            end
        end
    end

    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.ack      = (state_reg == S_ACK);
    assign bus.data_out = dout_reg;
    assign bus.misalign = mis_reg;
endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized: three instances (LATENCY 1, 3, 4) checked
// against a byte-array reference model with directed and random accesses.
module tb_dm_sized;
    localparam int NI     = 3;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0]       req_v, we_v, sx_v;
    logic [NI-1:0][1:0]  size_v;
    logic [NI-1:0][31:0] addr_v, din_v;
    logic [NI-1:0]       busy_v, ack_v, mis_v;
    logic [NI-1:0][31:0] dout_v;

    int          lat [NI] = '{1, 3, 4};
    logic [7:0]  mdl [NI][DEPTH];
    logic [31:0] mdl_dout [NI];
    int          n_cmp = 0;
    int          n_err = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
            dm_sized_if bus ();
            assign bus.req      = req_v[gi];
            assign bus.we       = we_v[gi];
            assign bus.size     = size_v[gi];
            assign bus.sign_ext = sx_v[gi];
            assign bus.addr     = addr_v[gi];
            assign bus.data_in  = din_v[gi];
            assign busy_v[gi]   = bus.busy;
            assign ack_v[gi]    = bus.ack;
            assign dout_v[gi]   = bus.data_out;
            assign mis_v[gi]    = bus.misalign;
            dm_sized #(.ADDR_W(ADDR_W), .LATENCY(L)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < DEPTH; a++) mdl[k][a] = 8'h00;
            mdl_dout[k] = 32'h0;
        end
    endtask

    // Reference: byte array, little-endian assembly, extension by arithmetic.
    task automatic model_access(input int k, input logic we, input logic [1:0] sz, input logic sx,
                                input logic [31:0] addr, input logic [31:0] din, output logic exp_mis);
        int     a, n;
        longint val;
        a = int'(addr % DEPTH);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_mis = (a % n) != 0;
        if (exp_mis) return;
        if (we) begin
            for (int j = 0; j < n; j++) mdl[k][a+j] = din[8*j +: 8];
        end else begin
            val = 0;
            for (int j = 0; j < n; j++) val += longint'(mdl[k][a+j]) << (8*j);
            if (sx && n < 4 && val >= (longint'(1) << (8*n-1))) val -= (longint'(1) << (8*n));
            mdl_dout[k] = val[31:0];
        end
    endtask

    // Single access from idle; caller sits 1 time unit after a rising edge.
    task automatic access(input int k, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] din);
        logic exp_mis;
        req_v[k] = 1'b1; we_v[k] = we; size_v[k] = sz; sx_v[k] = sx;
        addr_v[k] = addr; din_v[k] = din;
        model_access(k, we, sz, sx, addr, din, exp_mis);
        @(posedge clk); #1;
        req_v[k] = 1'b0; we_v[k] = 1'($urandom); size_v[k] = 2'($urandom);
        addr_v[k] = $urandom; din_v[k] = $urandom;
        for (int c = 1; c <= lat[k]; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            chk("busy", 32'(busy_v[k]), 32'd1);
            chk("ack", 32'(ack_v[k]), 32'(c == lat[k]));
            if (c == lat[k]) begin
                chk("misalign", 32'(mis_v[k]), 32'(exp_mis));
                chk("data_out", dout_v[k], mdl_dout[k]);
                $display("inst%0d L=%0d %s size=%0d sx=%0b addr=%h din=%h -> mis=%0b dout=%h",
                         k, lat[k], we ? "ST" : "LD", sz, sx, addr, din, mis_v[k], dout_v[k]);
            end
        end
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy_v[k]), 32'd0);
        chk("idle_ack", 32'(ack_v[k]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic em;
        rst = 1'b0;
        req_v = '0; we_v = '0; sx_v = '0; size_v = '0; addr_v = '0; din_v = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset mid-WAIT with a store pending (LATENCY=3)
        access(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("pre_reset_load", dout_v[1], 32'h11223344);
        req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'd2; addr_v[1] = 32'h10; din_v[1] = 32'hCAFEF00D;
        @(posedge clk); #1; req_v[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_busy", 32'(busy_v[k]), 32'd0);
            chk("rst_ack", 32'(ack_v[k]), 32'd0);
            chk("rst_mis", 32'(mis_v[k]), 32'd0);
            chk("rst_dout", dout_v[k], 32'd0);
        end
        clear_model();
        @(posedge clk); #1 rst = 1'b1;
        access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("post_reset_load", dout_v[1], 32'h0);

        // Word/byte/halfword on LATENCY=1
        access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("word_load", dout_v[0], 32'hDEADBEEF);
        access(0, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        chk("byte_zext", dout_v[0], 32'h000000DE);
        access(0, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        chk("half_sext", dout_v[0], 32'hFFFFBEEF);
        access(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        chk("byte_zext2", dout_v[0], 32'h000000BE);
        access(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'hAAAAAA55);
        access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("partial_store", dout_v[0], 32'hDE55BEEF);

        // Misaligned word store: flagged, no write, data_out held
        access(0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h12345678);
        chk("mis_dout_held", dout_v[0], 32'hDE55BEEF);
        access(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        chk("mis_no_write40", dout_v[0], 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        chk("mis_no_write44", dout_v[0], 32'h0);

        // Back-to-back loads on LATENCY=4, second one through an aliased address
        access(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D);
        access(2, 1'b1, 2'd2, 1'b0, 32'h24, 32'h13579BDF);
        req_v[2] = 1'b1; we_v[2] = 1'b0; size_v[2] = 2'd2; sx_v[2] = 1'b0; addr_v[2] = 32'h24;
        model_access(2, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, em);
        @(posedge clk); #1;
        addr_v[2] = 32'hFFFF_F020;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            chk("b2b_busy", 32'(busy_v[2]), 32'd1);
            chk("b2b_ack", 32'(ack_v[2]), 32'(c == 4 || c == 8));
            if (c == 4) chk("b2b_first", dout_v[2], 32'h13579BDF);
            if (c == 5) req_v[2] = 1'b0;
            if (c == 8) chk("b2b_alias", dout_v[2], 32'h0BADF00D);
        end
        model_access(2, 1'b0, 2'd2, 1'b0, 32'hFFFF_F020, 32'h0, em);
        $display("inst2 L=4 back-to-back LD 024 / LD fffff020 -> dout=%h", dout_v[2]);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(busy_v[2]), 32'd0);

        // A req pulse mid-access is dropped, not queued
        req_v[2] = 1'b1; we_v[2] = 1'b1; size_v[2] = 2'd2; addr_v[2] = 32'h30; din_v[2] = 32'hFFFFFFFF;
        model_access(2, 1'b1, 2'd2, 1'b0, 32'h30, 32'hFFFFFFFF, em);
        @(posedge clk); #1; req_v[2] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 2) begin
                req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 32'h34; din_v[2] = 32'h11111111;
            end
            if (c == 3) req_v[2] = 1'b0;
            chk("pulse_busy", 32'(busy_v[2]), 32'(c <= 4));
            chk("pulse_ack", 32'(ack_v[2]), 32'(c == 4));
        end
        $display("inst2 L=4 ST 030 with ignored req pulse at E+2");
        access(2, 1'b0, 2'd2, 1'b0, 32'h34, 32'h0);
        chk("pulse_no_write", dout_v[2], 32'h0);
        access(2, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        chk("pulse_store", dout_v[2], 32'hFFFFFFFF);

        // Random traffic on every instance
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 30; i++) begin
                logic        r_we, r_sx;
                logic [1:0]  r_sz;
                logic [31:0] r_addr, r_din;
                r_we   = 1'($urandom);
                r_sx   = 1'($urandom);
                r_sz   = 2'($urandom);
                r_addr = {$urandom_range(0, 32'h3FFFFF), 10'($urandom_range(0, 63))};
                r_din  = $urandom;
                access(k, r_we, r_sz, r_sx, r_addr, r_din);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_sized.md
# dm_sized

Parametrised data memory for the MIPS CPU datapath. It replaces the fixed word/byte-load data memory with these features:
- byte-addressed, little-endian storage of configurable depth;
- byte, halfword and word loads and stores, with sign or zero extension on loads;
- a request/acknowledge handshake with configurable access latency, so the pipeline can model wait states;
- a misalignment flag.

It sits between the ALU address output and the register-file write-back mux.

## Interface

Parameters:
- ADDR_W, 10: byte-address bits used. Depth is 2^ADDR_W bytes. Legal range 4..16.
- LATENCY, 1: cycles from request acceptance to ack. Legal range 1..8.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request. Sampled when the block is accepting (see Timing).
- we  in  1  1 = store, 0 = load. Sampled with req.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- sign_ext  in  1  loads only. 1 = sign-extend byte/halfword, 0 = zero-extend.
- addr  in  32  byte address. Only addr[ADDR_W-1:0] is used; upper bits are ignored (address wraps modulo depth).
- data_in  in  32  store data. The low 8/16/32 bits are used according to size.
- busy  out  1  high while an access is in flight (accept through ack cycle inclusive).
- ack  out  1  one-cycle pulse marking completion of an access.
- data_out  out  32  load result. Valid in the ack cycle and held until the next load ack.
- misalign  out  1  valid with ack. 1 = access rejected for misalignment.

## Operation

- Request fields (we, size, sign_ext, addr, data_in) are registered at acceptance. Later input changes do not affect the access.
- Alignment check at acceptance:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=00;
  - byte is always aligned.
- Misaligned access:
  - completes normally in timing (ack after LATENCY cycles) with misalign=1;
  - no memory byte is written;
  - data_out is unchanged.
- Store, little-endian: byte k of the data goes to address a+k.
  - Byte writes mem[a].
  - Halfword writes mem[a], mem[a+1].
  - Word writes mem[a..a+3].
  - No other byte changes.
- Load: assembles {mem[a+3], mem[a+2], mem[a+1], mem[a]}, truncated to size, then extended per sign_ext. Word loads ignore sign_ext.
- Aligned accesses never cross the top of memory, so no wrap occurs within a single access.
- State machine:
  - IDLE → WAIT on an accepted req. Load the down-counter with LATENCY-1.
  - WAIT decrements each cycle. When the count reaches 0 the next edge performs the access and enters ACK.
  - With LATENCY=1, IDLE goes → ACK directly.
  - ACK → WAIT/ACK if req is high (back-to-back access), otherwise → IDLE.
- Reset asserted (rst low), asynchronously:
  - state goes to IDLE; busy=0, ack=0, misalign=0, data_out=0;
  - all memory bytes are cleared to 0;
  - any in-flight access is aborted with no write.
- Reset deassertion is synchronous to clk. The first req is accepted at the first rising edge with rst high.

## Timing

- Accept rule: req is accepted at a rising edge where busy=0 or ack=1. req arriving while busy=1 and ack=0 is ignored; it is not queued.
- Latency is measured from the accepting edge E:
  - busy is high during cycles E+1 .. E+LATENCY;
  - ack, data_out and misalign are updated at edge E+LATENCY and visible in that cycle.
- Store commit occurs at the same edge as ack (E+LATENCY). A load accepted in the ack cycle of a store reads the stored data.
- Throughput is one access per LATENCY cycles with req held high.
- data_out changes only at a load ack with misalign=0, or on reset.

## Test plan

1. **Reset.** Hold rst=0 mid-WAIT, LATENCY=3, store pending.
   - Required: busy=ack=misalign=0 and data_out=0 immediately.
   - After release, a word load at 0x10 returns 0x00000000.
2. **Word store/load, LATENCY=1.**
   - Store 0xDEADBEEF at 0x20, then load word 0x20 → ack one cycle after accept, data_out=0xDEADBEEF.
   - Byte load 0x23, zero-extend → 0x000000DE.
3. **Sign extension.** After test 2:
   - halfword load 0x20, sign_ext=1 → 0xFFFFBEEF;
   - byte load 0x21, sign_ext=0 → 0x000000BE.
4. **Partial store.** Store byte 0x55 at 0x22 over 0xDEADBEEF (data_in=0xAAAAAA55).
   - Word load 0x20 → 0xDE55BEEF.
5. **Misalignment.** Word store of 0x12345678 at 0x41.
   - Required: ack with misalign=1.
   - Word load 0x40 still returns 0x00000000; data_out holds its prior value during the misaligned ack.
6. **Latency and back-to-back, LATENCY=4.**
   - req held high for two loads: busy high 4 cycles each, ack at E+4 and E+8.
   - A req pulse at E+2 is ignored.
   - addr=0xFFFF_F020 aliases to 0x020 (ADDR_W=10).
